// File: rtl/prop_sweep_pkg.sv
// Shared types and constants for the property sweep controller.
// Holds the FSM state encoding, result bit indices and the expected-value masks.
package prop_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int NUM_PROPS   = 9;
    localparam int NUM_VECTORS = 16;

    localparam int P_ALWAYS_TRUE  = 0;
    localparam int P_ALWAYS_FALSE = 1;
    localparam int P_DOUBLE_NEG   = 2;
    localparam int P_AND_IDENT    = 3;
    localparam int P_OR_IDENT     = 4;
    localparam int P_COMMUT       = 5;
    localparam int P_ASSOC        = 6;
    localparam int P_DEMORGAN_NAND = 7;
    localparam int P_DEMORGAN_NOR  = 8;

    // Results that must always read 1 regardless of the stimulus.
    localparam logic [NUM_PROPS-1:0] EXP_ONE_MASK =
        (NUM_PROPS'(1) << P_ALWAYS_TRUE)   |
        (NUM_PROPS'(1) << P_COMMUT)        |
        (NUM_PROPS'(1) << P_ASSOC)         |
        (NUM_PROPS'(1) << P_DEMORGAN_NAND) |
        (NUM_PROPS'(1) << P_DEMORGAN_NOR);

    // Results that must follow input a.
    localparam logic [NUM_PROPS-1:0] EXP_A_MASK =
        (NUM_PROPS'(1) << P_DOUBLE_NEG) |
        (NUM_PROPS'(1) << P_AND_IDENT)  |
        (NUM_PROPS'(1) << P_OR_IDENT);

    function automatic logic [NUM_PROPS-1:0] expected_res(input logic a);
        return EXP_ONE_MASK | (a ? EXP_A_MASK : '0);
    endfunction

endpackage

// File: rtl/prop_expect.sv
// Combinational mismatch generator: compares checker results with the
// values they must take for the current stimulus vector.
module prop_expect
    import prop_sweep_pkg::*;
(
    input  logic [3:0]           vec_i,
    input  logic [NUM_PROPS-1:0] res_i,
    output logic [NUM_PROPS-1:0] mism_o
);

    // Only input a influences the expected pattern; b, c and d do not.
    logic unused_bcd;
    assign unused_bcd = ^vec_i[2:0];

    // Mismatch is any bit differing from the expected pattern.
    assign mism_o = res_i ^ expected_res(vec_i[3]);

endmodule

// File: rtl/property_sweep_ctrl.sv
// Sweeps all 16 {a,b,c,d} vectors, lets each settle, then checks the
// property results and records the failure count and first failure.
module property_sweep_ctrl
    import prop_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NUM_PROPS-1:0] res,
    output logic [3:0]           vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [3:0]           fail_vec,
    output logic [NUM_PROPS-1:0] fail_mask,
    output logic [4:0]           err_count
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] VEC_LAST    = 4'(NUM_VECTORS - 1);

    state_e               state_q;
    logic [3:0]           vec_q;
    logic [3:0]           cnt_q;
    logic                 done_q;
    logic                 pass_q;
    logic [3:0]           fail_vec_q;
    logic [NUM_PROPS-1:0] fail_mask_q;
    logic [4:0]           err_q;
    logic [NUM_PROPS-1:0] mism;

    prop_expect u_expect (
        .vec_i  (vec_q),
        .res_i  (res),
        .mism_o (mism)
    );

    // Sweep FSM with settle counter and first-failure capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_vec_q  <= '0;
            fail_mask_q <= '0;
            err_q       <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                vec_q   <= '0;
                cnt_q   <= '0;
                pass_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            vec_q       <= '0;
                            cnt_q       <= '0;
                            err_q       <= '0;
                            fail_vec_q  <= '0;
                            fail_mask_q <= '0;
                            pass_q      <= 1'b0;
                            state_q     <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        if (cnt_q == SETTLE_LAST) begin
                            cnt_q   <= '0;
                            state_q <= ST_CHECK;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (|mism) begin
                            err_q <= err_q + 5'd1;
                            if (err_q == 5'd0) begin
                                fail_vec_q  <= vec_q;
                                fail_mask_q <= mism;
                            end
                        end
                        if (vec_q == VEC_LAST) begin
                            state_q <= ST_DONE;
                        end else begin
                            vec_q   <= vec_q + 4'd1;
                            state_q <= ST_APPLY;
                        end
                    end
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == 5'd0);
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign vec       = vec_q;
    assign busy      = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_property_sweep_ctrl.sv
// Randomized bench for property_sweep_ctrl, two instances (settle 1 and 3).
// Expected results come from a per-vector fault table and cycle arithmetic.
module tb_property_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    bit         sel = 1'b0;
    logic       st  = 1'b0;
    logic       ab  = 1'b0;
    logic [8:0] rs  = 9'h0;

    logic       start1, abort1, start3, abort3;
    logic [3:0] vec1, vec3, fv1, fv3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [8:0] fm1, fm3;
    logic [4:0] ec1, ec3;

    logic [3:0] o_vec, o_fv;
    logic       o_busy, o_done, o_pass;
    logic [8:0] o_fm;
    logic [4:0] o_ec;

    int checks = 0;
    int failures = 0;
    logic [8:0] flt [16];

    assign start1 = st & ~sel;
    assign abort1 = ab & ~sel;
    assign start3 = st & sel;
    assign abort3 = ab & sel;

    assign o_vec  = sel ? vec3  : vec1;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_pass = sel ? pass3 : pass1;
    assign o_fv   = sel ? fv3   : fv1;
    assign o_fm   = sel ? fm3   : fm1;
    assign o_ec   = sel ? ec3   : ec1;

    property_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .res(rs),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .fail_mask(fm1), .err_count(ec1)
    );

    property_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .res(rs),
        .vec(vec3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_vec(fv3), .fail_mask(fm3), .err_count(ec3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Correct checker output for vector index i (a = bit 3 of i).
    function automatic logic [8:0] golden(input int i);
        logic [8:0] g;
        g = 9'h1E1;
        if (i >= 8) g = g | 9'h01C;
        return g;
    endfunction

    task automatic set_faults(input int kind);
        for (int i = 0; i < 16; i++) begin
            case (kind)
                0: flt[i] = 9'h0;
                1: flt[i] = (i == 5) ? 9'h020 : 9'h0;
                2: flt[i] = 9'h004;
                default: flt[i] = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0;
            endcase
        end
    endtask

    // One sweep; abort_at<0 means no abort; hold keeps start high until done.
    task automatic sweep(input bit s, input int abort_at, input bit hold);
        int S, D, nv, ne, first, i;
        logic [3:0] efv;
        logic [8:0] efm;
        sel = s;
        S = s ? 3 : 1;
        D = 16 * (S + 1) + 1;
        @(negedge clk);
        st = 1'b1;
        ab = 1'b0;
        rs = 9'($urandom);
        @(posedge clk);
        for (int t = 0; t <= D + 2; t++) begin
            if (t > 0) @(posedge clk);
            #1;
            if (!hold || t >= D) st = 1'b0;
            i = t / (S + 1);
            nv = 16;
            if (abort_at >= 0) begin
                nv = 0;
                while (nv < 16 && nv * (S + 1) + S < abort_at) nv++;
            end
            ne = 0;
            first = -1;
            for (int k = 0; k < nv; k++) begin
                if (flt[k] != 9'h0) begin
                    ne++;
                    if (first < 0) first = k;
                end
            end
            efv = (first < 0) ? 4'h0 : 4'(first);
            efm = (first < 0) ? 9'h0 : flt[first];
            if (abort_at >= 0 && t == abort_at + 1) begin
                ab = 1'b0;
                chk("abort_busy", o_busy, 0);
                chk("abort_vec", o_vec, 0);
                chk("abort_pass", o_pass, 0);
                chk("abort_done", o_done, 0);
                chk("abort_err", o_ec, ne);
                chk("abort_fvec", o_fv, efv);
                chk("abort_fmask", o_fm, efm);
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    chk("abort_nodone", o_done, 0);
                    chk("abort_idle", o_busy, 0);
                end
                return;
            end
            if (t < 16 * (S + 1) && t % (S + 1) == S)
                rs = golden(i) ^ flt[i];
            else
                rs = 9'($urandom);
            if (t < 16 * (S + 1)) chk("vec", o_vec, i);
            chk("busy", o_busy, (t < 16 * (S + 1)) ? 1 : 0);
            chk("done", o_done, (t == D) ? 1 : 0);
            if (t == D || t == D + 2) begin
                chk("pass", o_pass, (ne == 0) ? 1 : 0);
                chk("err_count", o_ec, ne);
                chk("fail_vec", o_fv, efv);
                chk("fail_mask", o_fm, efm);
            end
            if (t == abort_at) ab = 1'b1;
        end
    endtask

    initial begin
        #1;
        chk("rst_vec", vec1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", ec1, 0);
        chk("rst_busy3", busy3, 0);
        @(negedge clk);
        rst = 1'b0;

        set_faults(0); sweep(0, -1, 0);
        set_faults(1); sweep(0, -1, 0);
        set_faults(2); sweep(0, -1, 0);
        set_faults(3); sweep(0, 10, 0);
        set_faults(0); sweep(0, -1, 0);

        // Reset between edges in mid-sweep.
        sel = 1'b0;
        @(negedge clk);
        st = 1'b1;
        rs = 9'h000;
        @(posedge clk);
        #1 st = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mrst_vec", o_vec, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_done", o_done, 0);
        chk("mrst_pass", o_pass, 0);
        chk("mrst_fvec", o_fv, 0);
        chk("mrst_fmask", o_fm, 0);
        chk("mrst_err", o_ec, 0);
        @(negedge clk);
        rst = 1'b0;

        // start and abort together: abort wins.
        @(negedge clk);
        st = 1'b1;
        ab = 1'b1;
        @(posedge clk);
        #1;
        chk("startabort_busy", o_busy, 0);
        @(negedge clk);
        st = 1'b0;
        ab = 1'b0;
        @(posedge clk);
        #1;
        chk("startabort_idle", o_busy, 0);
        set_faults(0); sweep(0, -1, 0);

        set_faults(0); sweep(1, -1, 1);
        set_faults(3); sweep(1, -1, 1);

        for (int n = 0; n < 4; n++) begin
            set_faults(3);
            sweep(0, ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 30)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
